pk_pack_stream_ctrl: RTL and testbench



---
 rtl/dilithium_pkg.sv | 27 ++
 rtl/t1_group_pack.sv | 13 +
 rtl/pk_pack_stream_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_pk_pack_stream_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants, controller state type and a byte-select helper
// for the 40-bit packed t1 group.
package dilithium_pkg;

    localparam int unsigned K                     = 6;
    localparam int unsigned N                     = 256;
    localparam int unsigned SEEDBYTES             = 32;
    localparam int unsigned COEF_W                = 32;
    localparam int unsigned T1_BITS               = 10;
    localparam int unsigned POLYT1_PACKEDBYTES    = 320;
    localparam int unsigned CRYPTO_PUBLICKEYBYTES = 1952;
    localparam int unsigned GROUP_W               = 4 * T1_BITS;

    typedef enum logic [2:0] {
        IDLE,
        RHO,
        FETCH,
        EMIT,
        DONE
    } pk_state_e;

    function automatic logic [7:0] group_byte(input logic [GROUP_W-1:0] grp,
                                              input logic [2:0]         idx);
        return 8'(grp >> {idx, 3'b000});
    endfunction

endpackage

// File: rtl/t1_group_pack.sv
// Packs four 10-bit t1 coefficients into one 40-bit little-endian group.
module t1_group_pack
    import dilithium_pkg::*;
(
    input  logic [3:0][T1_BITS-1:0] coef_in,
    output logic [GROUP_W-1:0]      group_out
);

    always_comb begin
        group_out = {coef_in[3], coef_in[2], coef_in[1], coef_in[0]};
    end

endmodule

// File: rtl/pk_pack_stream_ctrl.sv
// Streams the Dilithium public key (rho || packed t1) one byte per handshake.
// Optional macro PK_PACK_RANGE_CHECK_EN adds a sticky range_err_out flag.
module pk_pack_stream_ctrl #(
    parameter  int unsigned K         = dilithium_pkg::K,
    parameter  int unsigned N         = dilithium_pkg::N,
    parameter  int unsigned SEEDBYTES = dilithium_pkg::SEEDBYTES,
    parameter  int unsigned COEF_W    = dilithium_pkg::COEF_W,
    localparam int unsigned ADDR_W    = $clog2(K * N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_in,
    input  logic [8*SEEDBYTES-1:0] rho_in,
    output logic                   t1_rd_en_out,
    output logic [ADDR_W-1:0]      t1_addr_out,
    input  logic [COEF_W-1:0]      t1_data_in,
    output logic [7:0]             pk_byte_out,
    output logic                   pk_valid_out,
    input  logic                   pk_ready_in,
    output logic                   busy_out,
    output logic                   done_out
`ifdef PK_PACK_RANGE_CHECK_EN
    ,
    output logic                   range_err_out
`endif
);

    import dilithium_pkg::*;

    localparam int unsigned NGROUPS = K * N / 4;
    localparam int unsigned GRP_W   = $clog2(NGROUPS);
    localparam int unsigned RB_W    = $clog2(SEEDBYTES);

    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NGROUPS - 1);
    localparam logic [RB_W-1:0]  LAST_RHO = RB_W'(SEEDBYTES - 1);

    pk_state_e                 state_q, state_d;
    logic [8*SEEDBYTES-1:0]    rho_q, rho_d;
    logic [RB_W-1:0]           rb_q, rb_d;
    logic [2:0]                mb_q, mb_d;
    logic [2:0]                fc_q, fc_d;
    logic [GRP_W-1:0]          grp_q, grp_d;
    logic [3:0][T1_BITS-1:0]   coef_q, coef_d;
    logic                      rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [7:0]                byte_q, byte_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [GROUP_W-1:0]        group_d;
    logic                      handshake;

    assign handshake = valid_q && pk_ready_in;

    // Fetch cycle n (1..4) captures the read issued in cycle n-1.
    always_comb begin
        coef_d = coef_q;
        if (state_q == FETCH && fc_q != 3'd0) begin
            coef_d[2'(fc_q - 3'd1)] = t1_data_in[T1_BITS-1:0];
        end
    end

    // Packing the next-state slots lets byte 0 leave on the same edge as c3 lands.
    t1_group_pack u_pack (
        .coef_in   (coef_d),
        .group_out (group_d)
    );

    always_comb begin
        state_d = state_q;
        rho_d   = rho_q;
        rb_d    = rb_q;
        mb_d    = mb_q;
        fc_d    = fc_q;
        grp_d   = grp_q;
        rd_en_d = 1'b0;
        addr_d  = addr_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = RHO;
                    rho_d   = rho_in;
                    rb_d    = '0;
                    mb_d    = '0;
                    grp_d   = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    byte_d  = rho_in[7:0];
                end
            end

            RHO: begin
                if (handshake) begin
                    if (rb_q == LAST_RHO) begin
                        state_d = FETCH;
                        valid_d = 1'b0;
                        byte_d  = '0;
                        fc_d    = '0;
                        rd_en_d = 1'b1;
                        addr_d  = ADDR_W'({grp_q, 2'b00});
                    end else begin
                        rb_d   = rb_q + 1'b1;
                        byte_d = 8'(rho_q >> {rb_d, 3'b000});
                    end
                end
            end

            FETCH: begin
                if (fc_q == 3'd4) begin
                    state_d = EMIT;
                    mb_d    = '0;
                    valid_d = 1'b1;
                    byte_d  = group_byte(group_d, 3'd0);
                end else begin
                    fc_d = fc_q + 3'd1;
                    if (fc_q < 3'd3) begin
                        rd_en_d = 1'b1;
                        addr_d  = ADDR_W'({grp_q, 2'(fc_q + 3'd1)});
                    end
                end
            end

            EMIT: begin
                if (handshake) begin
                    if (mb_q == 3'd4) begin
                        valid_d = 1'b0;
                        byte_d  = '0;
                        if (grp_q == LAST_GRP) begin
                            state_d = DONE;
                            grp_d   = '0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = FETCH;
                            grp_d   = grp_q + 1'b1;
                            fc_d    = '0;
                            rd_en_d = 1'b1;
                            addr_d  = ADDR_W'({grp_d, 2'b00});
                        end
                    end else begin
                        mb_d   = mb_q + 3'd1;
                        byte_d = group_byte(group_d, mb_d);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rho_q   <= '0;
            rb_q    <= '0;
            mb_q    <= '0;
            fc_q    <= '0;
            grp_q   <= '0;
            coef_q  <= '0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rho_q   <= rho_d;
            rb_q    <= rb_d;
            mb_q    <= mb_d;
            fc_q    <= fc_d;
            grp_q   <= grp_d;
            coef_q  <= coef_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign t1_rd_en_out = rd_en_q;
    assign t1_addr_out  = addr_q;
    assign pk_byte_out  = byte_q;
    assign pk_valid_out = valid_q;
    assign busy_out     = busy_q;
    assign done_out     = done_q;

`ifdef PK_PACK_RANGE_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && start_in) begin
            err_d = 1'b0;
        end else if (state_q == FETCH && fc_q != 3'd0 &&
                     (|t1_data_in[COEF_W-1:T1_BITS])) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign range_err_out = err_q;
`else
    logic unused_upper;
    assign unused_upper = ^t1_data_in[COEF_W-1:T1_BITS];
`endif

endmodule

// File: tb/tb_pk_pack_stream_ctrl.sv
// Randomised self-checking bench for pk_pack_stream_ctrl against a byte-stream model.
`timescale 1ns/1ps
module tb_pk_pack_stream_ctrl;

    localparam int NC = 1536;
    localparam int NG = 384;
    localparam int NB = 1952;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_in;
    logic [255:0] rho_in;
    logic         t1_rd_en_out;
    logic [10:0]  t1_addr_out;
    logic [31:0]  t1_data_in;
    logic [7:0]   pk_byte_out;
    logic         pk_valid_out;
    logic         pk_ready_in;
    logic         busy_out;
    logic         done_out;
`ifdef PK_PACK_RANGE_CHECK_EN
    logic         range_err_out;
`endif

    pk_pack_stream_ctrl #(
        .K         (6),
        .N         (256),
        .SEEDBYTES (32),
        .COEF_W    (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_in     (start_in),
        .rho_in       (rho_in),
        .t1_rd_en_out (t1_rd_en_out),
        .t1_addr_out  (t1_addr_out),
        .t1_data_in   (t1_data_in),
        .pk_byte_out  (pk_byte_out),
        .pk_valid_out (pk_valid_out),
        .pk_ready_in  (pk_ready_in),
        .busy_out     (busy_out),
        .done_out     (done_out)
`ifdef PK_PACK_RANGE_CHECK_EN
        ,
        .range_err_out(range_err_out)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem   [NC];
    logic [7:0]  rho_b [32];
    logic [7:0]  exp_b [NB];
    logic [7:0]  got_b [NB];
    logic [7:0]  ref_b [NB];

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    bit stall_prev = 0;
    logic [7:0] stall_byte = 8'h00;

    // Synchronous coefficient RAM: data only meaningful the cycle after a read.
    always @(posedge clk) begin
        if (t1_rd_en_out) t1_data_in <= mem[t1_addr_out];
        else              t1_data_in <= $urandom();
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected stream: rho bytes, then each group's four 10-bit values as a
    // little-endian 40-bit integer split into five bytes.
    task automatic build_model();
        for (int b = 0; b < 32; b++) begin
            exp_b[b] = rho_b[b];
            rho_in[8*b +: 8] = rho_b[b];
        end
        for (int g = 0; g < NG; g++) begin
            longint unsigned v = 0;
            for (int i = 0; i < 4; i++)
                v += 64'(mem[4*g+i] % 1024) << (10*i);
            for (int m = 0; m < 5; m++)
                exp_b[32 + 5*g + m] = 8'((v >> (8*m)) % 256);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outs", {pk_valid_out, t1_rd_en_out, busy_out, done_out, pk_byte_out, t1_addr_out}, 0);
            stall_prev = 0;
        end else begin
            if (stall_prev)
                chk("stall_hold", {pk_valid_out, pk_byte_out}, {1'b1, stall_byte});
            if (pk_valid_out && pk_ready_in) begin
                if (hs_cnt < NB) begin
                    chk("stream_byte", pk_byte_out, exp_b[hs_cnt]);
                    got_b[hs_cnt] = pk_byte_out;
                end else begin
                    chk("extra_handshake", hs_cnt, NB - 1);
                end
                hs_cnt++;
            end
            stall_prev = pk_valid_out && !pk_ready_in;
            stall_byte = pk_byte_out;
            if (t1_rd_en_out) begin
                chk("rd_addr", t1_addr_out, rd_cnt);
                chk("rd_while_valid", pk_valid_out, 0);
                rd_cnt++;
            end
            if (pk_valid_out || t1_rd_en_out)
                chk("busy_during_stream", busy_out, 1);
            if (done_out) begin
                chk("done_handshakes", hs_cnt, NB);
                chk("done_reads", rd_cnt, NC);
                done_cnt++;
            end
        end
    end

    // mode 0: ready held high; 1: random backpressure; 2: ignored start then abort.
    task automatic run_stream(input int mode);
        bit found = 0;
        bit aborted = 0;
        bit poked = 0;
        bit f31 = 0;
        bit f1951 = 0;
        int c;
        build_model();
        hs_cnt = 0;
        rd_cnt = 0;
        done_cnt = 0;
        stall_prev = 0;
        pk_ready_in = 1'b1;
        @(posedge clk); #1 start_in = 1'b1;
        @(posedge clk); #1 start_in = 1'b0;
        chk("first_byte", {pk_valid_out, pk_byte_out}, {1'b1, rho_b[0]});
        chk("busy_after_start", busy_out, 1);
        for (c = 1; c <= 20000; c++) begin
            @(negedge clk);
            if (done_out) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
            if (mode == 1) begin
                pk_ready_in = ($urandom_range(0, 99) >= 30);
                if (pk_valid_out && hs_cnt == 31 && !f31) begin
                    pk_ready_in = 1'b0;
                    f31 = 1;
                end
                if (pk_valid_out && hs_cnt == 1951 && !f1951) begin
                    pk_ready_in = 1'b0;
                    f1951 = 1;
                end
            end
            if (mode == 2) begin
                start_in = 1'b0;
                if (!poked && pk_valid_out && hs_cnt == 40) begin
                    start_in = 1'b1;
                    poked = 1;
                end
                if (hs_cnt == 500) begin
                    rst_n = 1'b0;
                    #1;
                    chk("abort_outs_zero", {pk_valid_out, t1_rd_en_out, busy_out, done_out, pk_byte_out, t1_addr_out}, 0);
                    aborted = 1;
                    break;
                end
            end
        end
        if (aborted) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("abort_no_done", done_cnt, 0);
            chk("abort_handshakes", hs_cnt, 500);
            @(posedge clk); #1 rst_n = 1'b1;
        end else begin
            chk("done_seen", found, 1);
            if (mode == 0) chk("done_cycle", c, 3873);
            if (mode == 1) chk("forced_stalls", {f31, f1951}, 2'b11);
            chk("handshakes_total", hs_cnt, NB);
            @(negedge clk);
            chk("done_one_cycle", {done_out, busy_out}, 0);
            chk("done_count", done_cnt, 1);
        end
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        start_in = 1'b0;
        pk_ready_in = 1'b0;
        rho_in = '0;
        repeat (3) @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outs", {pk_valid_out, t1_rd_en_out, busy_out, done_out, pk_byte_out, t1_addr_out}, 0);
        end

        for (int j = 0; j < 32; j++) rho_b[j] = 8'(j);
        for (int i = 0; i < NC; i++) mem[i] = $urandom();
        run_stream(0);
        bad = 0;
        for (int j = 0; j < 32; j++) if (got_b[j] !== 8'(j)) bad++;
        chk("rho_bytes_literal", bad, 0);

        for (int i = 0; i < NC; i++) mem[i] = 32'h0000_03FF;
        run_stream(0);
        bad = 0;
        for (int j = 32; j < NB; j++) if (got_b[j] !== 8'hFF) bad++;
        chk("all_ones_literal", bad, 0);
`ifdef PK_PACK_RANGE_CHECK_EN
        chk("range_err_clean", range_err_out, 0);
`endif

        for (int j = 0; j < 32; j++) rho_b[j] = 8'($urandom());
        for (int i = 0; i < NC; i++) mem[i] = $urandom();
        mem[0] = 32'hABC0_0001;
        mem[1] = 32'h0000_0402;
        mem[2] = 32'h0000_0003;
        mem[3] = 32'hFFFF_FC04;
        run_stream(0);
        chk("grp0_model_literal", {exp_b[36], exp_b[35], exp_b[34], exp_b[33], exp_b[32]}, 40'h01_00_30_08_01);
        chk("grp0_dut_literal", {got_b[36], got_b[35], got_b[34], got_b[33], got_b[32]}, 40'h01_00_30_08_01);
`ifdef PK_PACK_RANGE_CHECK_EN
        chk("range_err_dirty", range_err_out, 1);
`endif
        for (int j = 0; j < NB; j++) ref_b[j] = got_b[j];

        run_stream(1);
        bad = 0;
        for (int j = 0; j < NB; j++) if (got_b[j] !== ref_b[j]) bad++;
        chk("backpressure_same_stream", bad, 0);
        pk_ready_in = 1'b1;

        run_stream(2);
        for (int i = 0; i < NC; i++) mem[i] = $urandom();
        run_stream(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
